fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences instruction fetch from the combinational program memory (ROM) and buffers results for the core.
- Owns the fetch PC and drives the ROM byte address.
- Captures each word with its PC into a small prefetch FIFO and presents a valid/ready stream to decode.
- Handles redirects (branch/jump) by flushing and restarting the fetch.

Parameters:
- DATA_WIDTH, 32, width of address, instruction and PC.
- MEMORY_DEPTH, 32, number of ROM words; fetch stops past the last word.
- FIFO_DEPTH, 2, prefetch entries (power of two, 2..8).
- RESET_PC, 32'h0040_0000, fetch PC after reset; ROM word index = PC[16:2].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Enable_i  input  1  1 = fetching allowed; 0 = no new pushes (FIFO still drains).
- Redirect_i  input  1  one-cycle request to restart fetch at Redirect_Addr_i.
- Redirect_Addr_i  input  DATA_WIDTH  new fetch byte address.
- Mem_Address_o  output  DATA_WIDTH  byte address to ROM; equals fetch_pc.
- Mem_Instruction_i  input  DATA_WIDTH  combinational ROM data for Mem_Address_o.
- Instr_Valid_o  output  1  FIFO head valid.
- Instr_Ready_i  input  1  core accepts head this cycle.
- Instr_o  output  DATA_WIDTH  head instruction.
- Instr_PC_o  output  DATA_WIDTH  PC of head instruction.
- Misaligned_o  output  1  one-cycle pulse: redirect address had [1:0] != 0.
- Out_Of_Range_o  output  1  level: fetch_pc word index >= MEMORY_DEPTH.

Behaviour:
- Reset (async, reset==0):
  - fetch_pc = RESET_PC; FIFO count = 0; read/write pointers = 0.
  - Instr_Valid_o = 0; Instr_o = 0; Instr_PC_o = 0; Misaligned_o = 0.
- Outputs:
  - Mem_Address_o = fetch_pc (combinational). The ROM returns data in the same cycle.
  - Instr_o / Instr_PC_o come from registered FIFO storage at the read pointer.
  - Instr_Valid_o = (count != 0).
- Events, evaluated at each rising edge:
  - pop = Instr_Valid_o & Instr_Ready_i.
  - push = Enable_i & !Redirect_i & !Out_Of_Range_o & (count < FIFO_DEPTH | pop).
- push: write {fetch_pc, Mem_Instruction_i} at the write pointer, advance the pointer, fetch_pc += 4 (modulo 2^DATA_WIDTH).
- pop: advance the read pointer.
- Count update: count += push - pop. Simultaneous push and pop at full is legal and count stays at FIFO_DEPTH.
- Redirect (highest priority):
  - FIFO flushed: count = 0, pointers = 0.
  - Any pop that cycle is still consumed by the core, but nothing is pushed.
  - fetch_pc = {Redirect_Addr_i[DW-1:2], 2'b00}.
  - Misaligned_o = |Redirect_Addr_i[1:0] for exactly the next cycle.
- Redirect latency:
  - Instr_Valid_o = 0 in the cycle after the redirect edge.
  - The first new instruction is pushed at the next edge and is valid two edges after the redirect.
- Startup latency: the first instruction (at RESET_PC) is valid after the first rising edge with reset high and Enable_i = 1.
- Wrap pointers: read/write pointers wrap modulo FIFO_DEPTH.
- Out_Of_Range_o:
  - Combinational: (fetch_pc[16:2] >= MEMORY_DEPTH).
  - While high, fetching halts and the FIFO drains normally.
  - Cleared only by a redirect to an in-range address, or by reset.
- Enable_i low: fetch_pc frozen, no pushes, pops continue.
- Redirect_i while Enable_i = 0: redirect still applies.
- Reset mid-stream: immediate return to reset state, with no partial pushes.

Decomposition:
- Shared package fetch_pkg:
  - WORD_BYTES = 4 and PC_INCREMENT = 4.
  - ROM index slice constants (bits 16:2).
  - Default RESET_PC.
- One sub-module, sync_fifo: parameterised width (2*DATA_WIDTH) and depth.
  - Ports: push, pop, flush, count, full, empty.
  - fetch_sequencer instantiates it and keeps fetch_pc, the push/pop/redirect logic and the flags.

Test Plan:
- Reset release, Enable_i = 1, Instr_Ready_i = 1, ROM[0..3] = 0xA0..0xA3:
  - Valid after 1 edge with PC 0x00400000 / Instr 0xA0.
  - Then one instruction per cycle at PC 0x00400004, 0x00400008, ...
- Instr_Ready_i = 0 for 5 cycles:
  - count saturates at 2; Mem_Address_o holds 0x00400008.
  - On release, the head sequence 0xA0, 0xA1, 0xA2 arrives without a gap or duplicate.
- Redirect_i with Redirect_Addr_i = 0x00400010 while the FIFO is full:
  - Next cycle Valid = 0.
  - Two edges later head PC = 0x00400010 with ROM[4] data.
  - No stale entries appear.
- Redirect to 0x00400013:
  - Misaligned_o pulses exactly 1 cycle.
  - fetch_pc = 0x00400010.
- Redirect to 0x0040007C with MEMORY_DEPTH = 32:
  - One push (word 31).
  - Then Out_Of_Range_o = 1 with no further pushes; the FIFO drains to empty.
- Reset asserted while count = 2 and a push is pending:
  - Outputs go to reset values immediately, asynchronously, with no edge needed.
  - Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction fetch path: word size, PC step, the
// PC bit slice that forms the ROM word index, and the default reset PC.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned WORD_BYTES   = 4;
    localparam int unsigned PC_INCREMENT = 4;

    // Byte-offset bits inside one instruction word.
    localparam int unsigned OFFSET_BITS  = $clog2(WORD_BYTES);

    // ROM word index = PC[ROM_IDX_MSB:ROM_IDX_LSB].
    localparam int unsigned ROM_IDX_MSB  = 16;
    localparam int unsigned ROM_IDX_LSB  = 2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a synchronous flush.
// The head entry (rdata_o) is read directly from storage at the read pointer.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   push_i   in   write wdata_i (ignored when full unless popping the same cycle)
//   pop_i    in   discard head entry (ignored when empty)
//   flush_i  in   empty the FIFO, reset both pointers; overrides push/pop
//   wdata_i  in   entry to write
//   rdata_o  out  head entry
//   count_o  out  number of stored entries
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO may still accept a write when the head leaves the same cycle:
    // the write lands in the slot being vacated.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push_ok) wptr_d = wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is reset because the head entry is visible on the outputs
    // and must read as zero out of reset; for a small FIFO this is cheap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule : sync_fifo

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the fetch PC, reads the combinational ROM at that PC, and buffers each
// {PC, instruction} pair in a prefetch FIFO presented to decode as a
// valid/ready stream. A redirect flushes the FIFO and restarts fetch.
//
// Ports:
//   clk                in   rising-edge clock
//   reset              in   asynchronous active-low reset
//   Enable_i           in   allow new fetches (FIFO drains regardless)
//   Redirect_i         in   restart fetch at Redirect_Addr_i (highest priority)
//   Redirect_Addr_i    in   new fetch byte address (low bits dropped)
//   Mem_Address_o      out  ROM byte address = fetch PC
//   Mem_Instruction_i  in   ROM data for Mem_Address_o, same cycle
//   Instr_Valid_o      out  head entry valid
//   Instr_Ready_i      in   decode takes the head entry this cycle
//   Instr_o            out  head instruction
//   Instr_PC_o         out  PC of head instruction
//   Misaligned_o       out  pulse: previous redirect address had offset bits set
//   Out_Of_Range_o     out  fetch PC is past the last ROM word; fetch halted
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH   = 32,
    parameter int unsigned          MEMORY_DEPTH = 32,
    parameter int unsigned          FIFO_DEPTH   = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_Addr_i,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    input  logic [DATA_WIDTH-1:0] Mem_Instruction_i,
    output logic                  Instr_Valid_o,
    input  logic                  Instr_Ready_i,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic [DATA_WIDTH-1:0] Instr_PC_o,
    output logic                  Misaligned_o,
    output logic                  Out_Of_Range_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    misaligned_q;

    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    logic pop;
    logic push;
    logic out_of_range;

    assign out_of_range   = 32'(fetch_pc_q[ROM_IDX_MSB:ROM_IDX_LSB]) >= MEMORY_DEPTH;
    assign Out_Of_Range_o = out_of_range;
    assign Mem_Address_o  = fetch_pc_q;
    assign Misaligned_o   = misaligned_q;

    assign Instr_Valid_o  = (fifo_count != '0);
    assign Instr_PC_o     = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign Instr_o        = fifo_head[DATA_WIDTH-1:0];

    assign pop  = ~fifo_empty & Instr_Ready_i;
    // A redirect suppresses the push: the word at the old PC is already stale.
    assign push = Enable_i & ~Redirect_i & ~out_of_range & (~fifo_full | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (Redirect_i) begin
            fetch_pc_d = {Redirect_Addr_i[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INCREMENT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q   <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            misaligned_q <= Redirect_i & (|Redirect_Addr_i[OFFSET_BITS-1:0]);
        end
    end

    sync_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (Redirect_i),
        .wdata_i ({fetch_pc_q, Mem_Instruction_i}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench: a queue-based reference model of the prefetch buffer is
// compared against the DUT on every falling edge; directed phases pin the
// model with hand-computed literals, then a randomized phase exercises
// enable/ready/redirect interleavings.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          DW        = 32;
    localparam int          MEM_DEPTH = 32;
    localparam int          FD        = 2;
    localparam logic [31:0] RST_PC    = 32'h0040_0000;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          en         = 1'b0;
    logic          redir      = 1'b0;
    logic [DW-1:0] redir_addr = '0;
    logic          ready      = 1'b0;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_instr;
    logic          valid;
    logic [DW-1:0] instr;
    logic [DW-1:0] instr_pc;
    logic          mis;
    logic          oor;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ---------------- ROM (combinational) ----------------
    logic [31:0] rom [MEM_DEPTH];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        int idx;
        idx = int'(a[16:2]);
        if (idx < MEM_DEPTH) return rom[idx];
        return 32'hDEAD_BEEF;
    endfunction

    assign mem_instr = rom_word(mem_addr);

    fetch_sequencer #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (MEM_DEPTH),
        .FIFO_DEPTH   (FD),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Enable_i          (en),
        .Redirect_i        (redir),
        .Redirect_Addr_i   (redir_addr),
        .Mem_Address_o     (mem_addr),
        .Mem_Instruction_i (mem_instr),
        .Instr_Valid_o     (valid),
        .Instr_Ready_i     (ready),
        .Instr_o           (instr),
        .Instr_PC_o        (instr_pc),
        .Misaligned_o      (mis),
        .Out_Of_Range_o    (oor)
    );

    // ---------------- reference model ----------------
    // The buffer is a queue of {pc, instr}; the fetch PC and the misaligned
    // flag are plain variables updated from the rules at each rising edge.
    logic [63:0] mq [$];
    logic [31:0] m_pc  = RST_PC;
    logic        m_mis = 1'b0;
    bit          m_pop;
    bit          m_push;

    function automatic bit m_oor();
        return int'(m_pc[16:2]) >= MEM_DEPTH;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_pc  = RST_PC;
            m_mis = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && ready;
            m_push = en && !redir && !m_oor() && ((mq.size() < FD) || m_pop);
            if (m_pop) void'(mq.pop_front());
            m_mis = redir && (redir_addr[1:0] != 2'b00);
            if (redir) begin
                mq.delete();
                m_pc = {redir_addr[31:2], 2'b00};
            end else if (m_push) begin
                mq.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_head(input string name, input logic [31:0] pc, input logic [31:0] ins);
        check({name, "_valid"}, {31'b0, valid}, 32'd1);
        check({name, "_pc"}, instr_pc, pc);
        check({name, "_instr"}, instr, ins);
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_valid", {31'b0, valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("model_head_pc", instr_pc, mq[0][63:32]);
            check("model_head_instr", instr, mq[0][31:0]);
        end
        check("model_mem_addr", mem_addr, m_pc);
        check("model_oor", {31'b0, oor}, {31'b0, m_oor()});
        check("model_misaligned", {31'b0, mis}, {31'b0, m_mis});
    end

    task automatic do_redirect(input logic [31:0] a);
        redir      = 1'b1;
        redir_addr = a;
        @(negedge clk);
        redir      = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) rom[i] = 32'hA0 + 32'(i);

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_mis", {31'b0, mis}, 32'd0);
        check("rst_addr", mem_addr, RST_PC);

        // Startup: one instruction per cycle.
        reset = 1'b1;
        en    = 1'b1;
        ready = 1'b1;
        @(negedge clk); expect_head("start0", 32'h0040_0000, 32'hA0);
        @(negedge clk); expect_head("start1", 32'h0040_0004, 32'hA1);
        @(negedge clk); expect_head("start2", 32'h0040_0008, 32'hA2);

        // Back-pressure: restart at RESET_PC with decode stalled.
        ready = 1'b0;
        do_redirect(32'h0040_0000);
        check("stall_flush_valid", {31'b0, valid}, 32'd0);
        repeat (5) @(negedge clk);
        check("stall_addr", mem_addr, 32'h0040_0008);
        expect_head("stall_head", 32'h0040_0000, 32'hA0);
        ready = 1'b1;
        @(negedge clk); expect_head("drain1", 32'h0040_0004, 32'hA1);
        @(negedge clk); expect_head("drain2", 32'h0040_0008, 32'hA2);
        ready = 1'b0;
        repeat (3) @(negedge clk);

        // Redirect while full.
        do_redirect(32'h0040_0010);
        check("redir_valid0", {31'b0, valid}, 32'd0);
        @(negedge clk); expect_head("redir_head", 32'h0040_0010, 32'hA4);
        @(negedge clk); expect_head("redir_hold", 32'h0040_0010, 32'hA4);

        // Misaligned redirect.
        do_redirect(32'h0040_0013);
        check("mis_pulse", {31'b0, mis}, 32'd1);
        check("mis_addr", mem_addr, 32'h0040_0010);
        @(negedge clk);
        check("mis_clear", {31'b0, mis}, 32'd0);

        // Last ROM word, then out of range.
        do_redirect(32'h0040_007C);
        check("end_addr", mem_addr, 32'h0040_007C);
        check("end_oor0", {31'b0, oor}, 32'd0);
        @(negedge clk);
        expect_head("end_word31", 32'h0040_007C, 32'hBF);
        check("end_oor1", {31'b0, oor}, 32'd1);
        repeat (4) @(negedge clk);
        check("end_halt_addr", mem_addr, 32'h0040_0080);
        expect_head("end_still", 32'h0040_007C, 32'hBF);
        ready = 1'b1;
        @(negedge clk);
        check("end_drained", {31'b0, valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("end_empty", {31'b0, valid}, 32'd0);
        check("end_oor_hold", {31'b0, oor}, 32'd1);
        do_redirect(32'h0040_0000);
        check("oor_cleared", {31'b0, oor}, 32'd0);

        // Asynchronous reset mid-stream with a push pending.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid}, 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_pc", instr_pc, 32'd0);
        check("arst_mis", {31'b0, mis}, 32'd0);
        check("arst_addr", mem_addr, RST_PC);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); expect_head("restart", 32'h0040_0000, 32'hA0);

        // Randomized phase, checked by the model every cycle.
        for (int c = 0; c < 600; c++) begin
            en    = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 9) < 6);
            redir = ($urandom_range(0, 19) == 0);
            redir_addr = RST_PC + 32'($urandom_range(0, 40)) * 32'd4
                                + 32'($urandom_range(0, 3));
            @(negedge clk);
        end
        redir = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
